// File: rtl/ring_link_fifo.sv
// ---------------------------------------------------------------------------
// ring_link_fifo
//   Elastic buffer placed on one direction of one inter-cluster ring hop.
//   Registered circular buffer with valid/ready on both sides; the outputs
//   depend only on stored state, so there is no fall-through path from the
//   upstream side and no combinational path from ready_i to ready_o.
//
// Parameters
//   DataWidth : payload width in bits
//   Depth     : number of storage entries (>= 1, any integer)
//   CntWidth  : width of the occupancy count (derived)
//
// Ports
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset
//   flush_i    in   synchronous clear of all entries (wins over push/pop)
//   data_i     in   upstream payload
//   valid_i    in   upstream valid
//   ready_o    out  upstream ready (not full)
//   data_o     out  head entry, 0 while empty
//   valid_o    out  downstream valid (not empty)
//   ready_i    in   downstream ready
//   usage_o    out  number of stored entries
//
// Optional build macro RING_LINK_FIFO_STATS_EN adds:
//   stall_cnt_o  out  saturating count of cycles with valid_o && !ready_i
//   max_usage_o  out  high-water mark of the occupancy count
// ---------------------------------------------------------------------------
module ring_link_fifo #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 2,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
`ifdef RING_LINK_FIFO_STATS_EN
  output logic [31:0]          stall_cnt_o,
  output logic [CntWidth-1:0]  max_usage_o,
`endif
  output logic [CntWidth-1:0]  usage_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  // Pointer advance with wrap at Depth-1; Depth need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(Depth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrWidth-1:0]  r_wptr;
  logic [PtrWidth-1:0]  r_rptr;
  logic [CntWidth-1:0]  r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [CntWidth-1:0]  w_count_nxt;

  assign w_full  = (r_count == CntWidth'(Depth));
  assign w_empty = (r_count == '0);

  // Handshakes use the registered flags only, so a pop on a full buffer
  // never opens the upstream side in the same cycle.
  assign w_push  = valid_i && !w_full;
  assign w_pop   = !w_empty && ready_i;

  assign ready_o = !w_full;
  assign valid_o = !w_empty;
  assign usage_o = r_count;
  assign data_o  = w_empty ? '0 : r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    if (flush_i) begin
      w_count_nxt = '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Control state: pointers and count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (flush_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= ptr_inc(r_wptr);
        if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      end
    end
  end

  // Storage is not reset; data_o is masked to 0 while empty. A word written
  // during a flush is orphaned because the pointers return to 0.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

`ifdef RING_LINK_FIFO_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0]         r_stall_cnt;
  logic [CntWidth-1:0] r_max_usage;

  // High-water mark tracks the post-update count so it is current the
  // cycle after the entry lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_max_usage <= '0;
    end else if (flush_i) begin
      r_stall_cnt <= '0;
      r_max_usage <= '0;
    end else begin
      if (!w_empty && !ready_i) r_stall_cnt <= sat_inc32(r_stall_cnt);
      if (w_count_nxt > r_max_usage) r_max_usage <= w_count_nxt;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign max_usage_o = r_max_usage;
`endif

endmodule

// File: doc/ring_link_fifo.md
Name: ring_link_fifo

Overview:
- Elastic buffer stage inserted on each inter-cluster ring link, between one ring router's left/right output and the neighbouring router's input.
- Decouples router-to-router timing with a registered, depth-configurable FIFO.
- Carries elen_t-wide slide-unit payloads with a valid/ready handshake on both sides.
- One instance per direction per hop in ara_cluster.

Parameters:
- DataWidth, 64, payload width in bits (matches $bits(elen_t)).
- Depth, 2, number of storage entries, ≥1, any integer (not restricted to powers of two).
- CntWidth, $clog2(Depth+1), localparam, width of the occupancy count.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous clear of all entries
- data_i  in  DataWidth  upstream payload
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  DataWidth  downstream payload (head entry)
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- usage_o  out  CntWidth  current number of stored entries

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: all pointers 0, count 0, valid_o=0, ready_o=1, usage_o=0, data_o=0. Storage contents are don't-care, but data_o must read 0 while empty.
- Storage: circular buffer with write pointer wptr, read pointer rptr and a count register.
  - Each pointer wraps from Depth-1 to 0. A Depth=3 instance must wrap 2→0.
- Push: when valid_i && ready_o, data_i is written at wptr and wptr advances.
- Pop: when valid_o && ready_i, rptr advances.
- ready_o = (count != Depth).
  - Purely registered-state based; no combinational path from ready_i to ready_o.
  - When full, a same-cycle pop does not enable a push.
- valid_o = (count != 0). data_o = mem[rptr], or 0 when empty.
  - No combinational path from data_i/valid_i to the outputs (no fall-through).
- Latency: a word pushed into an empty FIFO appears on valid_o/data_o the cycle after the push, so minimum latency is 1 cycle.
  - Throughput is 1 word/cycle whenever 0 < count < Depth.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- usage_o = count.
- Ordering: strict FIFO. No drop and no duplication under any backpressure pattern.
- Upstream protocol: once valid_i is high, data_i must stay stable until accepted (AXI-style).
  - Downstream valid_o/data_o likewise stay stable while ready_i=0; the block guarantees this.
- flush_i: next cycle, count=0 and wptr=rptr=0.
  - flush_i has priority over a simultaneous push and pop; the pushed word is discarded.
  - Upstream still sees the handshake as completed that cycle; this is intended for ring reconfiguration only.
- Reset mid-operation: all stored words are lost. Outputs go to reset values immediately (asynchronously).
- Depth=1: the block alternates full/empty and throughput is at most 1 word per 2 cycles. This is a legal configuration.

Optional Feature:
- Macro: RING_LINK_FIFO_STATS_EN.
- When defined, two extra output ports exist:
  - stall_cnt_o (32 bits): saturating count of cycles with valid_o && !ready_i. Holds at 0xFFFF_FFFF.
  - max_usage_o (CntWidth bits): high-water mark of count.
  - Both reset to 0 and are cleared by flush_i.
- When undefined, these ports and their registers are absent and behaviour is otherwise identical.

Test Plan:
- Depth=2, ready_i=1, push 0xA, 0xB, 0xC on consecutive cycles → valid_o rises 1 cycle after the first push; data_o=0xA, 0xB, 0xC on consecutive cycles; usage_o never exceeds 1.
- Depth=2, ready_i=0, push 0x1, 0x2, 0x3 → ready_o=0 after the second push; 0x3 held upstream. Raise ready_i → output 0x1, 0x2, 0x3 in order with no loss.
- Depth=3, random valid_i/ready_i over 1000 words with incrementing data → scoreboard exact order; pointer wrap 2→0 exercised; usage_o always ≤3.
- Full FIFO (Depth=2) with valid_i=1 and ready_i=1 in the same cycle → pop occurs, no push that cycle (ready_o=0), usage_o goes 2→1.
- flush_i asserted with 2 entries plus a simultaneous push → next cycle usage_o=0, valid_o=0, data_o=0; a following push of 0x55 appears as the head.
- With RING_LINK_FIFO_STATS_EN: hold ready_i=0 for 5 cycles with valid_o=1 → stall_cnt_o=5 and max_usage_o=Depth. After flush_i, both read 0.
